fullxor_sched: RTL and testbench

- Controller for the masked full-XOR share-compression datapath (N_SHARES Boolean shares refreshed, registered and XOR-collapsed into one K_WIDTH word).
- Arbitrates round-robin between N_REQ requesters and pairs each accepted share vector with exactly one fresh randomness word from the PRNG.
- Sequences the datapath dvld/ena controls and returns the unmasked result, tagged with the requester id.
- Only one operation is in flight at a time, so randomness is never reused and shares from different requesters never coexist in the datapath register.

---
 rtl/fullxor_sched.sv | 193 +++++++++++++++++++
 tb/tb_fullxor_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fullxor_sched.sv
`timescale 1ns/1ps
// fullxor_sched: controller for the masked full-XOR share-compression datapath.
// Grants one requester at a time (round-robin), pairs it with one fresh PRNG
// word, sequences the datapath dvld/ena controls and returns the collapsed
// result tagged with the requester id.
// Optional build macro FULLXOR_SCHED_ZEROIZE_EN adds two clean-up states that
// overwrite the datapath share register with zeros after every response.
module fullxor_sched #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 8,
  parameter int RANDNUM  = 12,
  parameter int N_REQ    = 2,
  parameter int WAIT_MAX = 4,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_vld,
  input  logic [N_REQ*MASKWIDTH-1:0]   req_x,
  output logic [N_REQ-1:0]             req_rdy,
  input  logic                         rnd_vld,
  input  logic [K_WIDTH*RANDNUM-1:0]   rnd_data,
  output logic                         rnd_rdy,
  output logic                         dp_dvld,
  output logic                         dp_ena,
  output logic [K_WIDTH*RANDNUM-1:0]   dp_rnd,
  output logic [MASKWIDTH-1:0]         dp_x,
  input  logic [K_WIDTH-1:0]           dp_z,
  input  logic                         dp_ovld,
  output logic                         rsp_vld,
  output logic [K_WIDTH-1:0]           rsp_z,
  output logic [ID_W-1:0]              rsp_id,
  input  logic                         rsp_rdy,
  output logic                         busy,
  output logic                         err
);

  // wcnt only has to reach WAIT_MAX-1
  localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RESP = 3'd2
`ifdef FULLXOR_SCHED_ZEROIZE_EN
    ,
    ST_CLR0 = 3'd3,
    ST_CLR1 = 3'd4
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [K_WIDTH-1:0]  rsp_z_q, rsp_z_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                err_q, err_d;

  logic                req_any;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;
  logic [MASKWIDTH-1:0] grant_x;
  logic [ID_W-1:0]     next_ptr;

  // Pointer handed to the requester after the one currently owning the datapath
  assign next_ptr = ID_W'((int'(id_q) + 1) % N_REQ);

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    req_any   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!req_any && req_vld[cand]) begin
        req_any   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the granted requester's share vector
  always_comb begin
    grant_x = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_idx == ID_W'(r)) begin
        grant_x = req_x[r*MASKWIDTH +: MASKWIDTH];
      end
    end
  end

  // Next-state and output decode; everything idles at zero unless a state drives it
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    wcnt_d   = wcnt_q;
    rsp_z_d  = rsp_z_q;
    rsp_id_d = rsp_id_q;
    err_d    = err_q;
    req_rdy  = '0;
    rnd_rdy  = 1'b0;
    dp_dvld  = 1'b0;
    dp_ena   = 1'b0;
    dp_x     = '0;
    dp_rnd   = '0;
    rsp_vld  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any && rnd_vld) begin
          req_rdy = N_REQ'(1) << grant_idx;
          rnd_rdy = 1'b1;
          dp_x    = grant_x;
          dp_rnd  = rnd_data;
          dp_dvld = 1'b1;
          dp_ena  = 1'b1;
          id_d    = grant_idx;
          wcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dp_ena = 1'b1;
        if (dp_ovld) begin
          rsp_z_d  = dp_z;
          rsp_id_d = id_q;
          state_d  = ST_RESP;
        end else if (wcnt_q == WCNT_W'(WAIT_MAX - 1)) begin
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_RESP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) begin
          rr_ptr_d = next_ptr;
`ifdef FULLXOR_SCHED_ZEROIZE_EN
          rsp_z_d  = '0;
          state_d  = ST_CLR0;
`else
          state_d  = ST_IDLE;
`endif
        end
      end
`ifdef FULLXOR_SCHED_ZEROIZE_EN
      ST_CLR0: begin
        dp_dvld = 1'b1;
        dp_ena  = 1'b1;
        state_d = ST_CLR1;
      end
      ST_CLR1: begin
        dp_ena  = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      wcnt_q   <= '0;
      rsp_z_q  <= '0;
      rsp_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      wcnt_q   <= wcnt_d;
      rsp_z_q  <= rsp_z_d;
      rsp_id_q <= rsp_id_d;
      err_q    <= err_d;
    end
  end

  assign rsp_z  = rsp_z_q;
  assign rsp_id = rsp_id_q;
  assign err    = err_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fullxor_sched.sv
`timescale 1ns/1ps
// Bench for fullxor_sched: a transaction-level model checked every cycle,
// a simple nominal-latency datapath stub, and directed scenarios with
// hand-computed results.
module tb_fullxor_sched;

  localparam int K_WIDTH   = 32;
  localparam int N_SHARES  = 8;
  localparam int RANDNUM   = 12;
  localparam int N_REQ     = 2;
  localparam int WAIT_MAX  = 4;
  localparam int MASKWIDTH = K_WIDTH * N_SHARES;
  localparam int ID_W      = 1;
  localparam int RW        = K_WIDTH * RANDNUM;
`ifdef FULLXOR_SCHED_ZEROIZE_EN
  localparam bit ZEROIZE  = 1'b1;
  localparam int INTERVAL = 5;
`else
  localparam bit ZEROIZE  = 1'b0;
  localparam int INTERVAL = 3;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [N_REQ-1:0]           req_vld;
  logic [N_REQ*MASKWIDTH-1:0] req_x;
  logic [N_REQ-1:0]           req_rdy;
  logic                       rnd_vld;
  logic [RW-1:0]              rnd_data;
  logic                       rnd_rdy;
  logic                       dp_dvld;
  logic                       dp_ena;
  logic [RW-1:0]              dp_rnd;
  logic [MASKWIDTH-1:0]       dp_x;
  logic [K_WIDTH-1:0]         dp_z;
  logic                       dp_ovld;
  logic                       rsp_vld;
  logic [K_WIDTH-1:0]         rsp_z;
  logic [ID_W-1:0]            rsp_id;
  logic                       rsp_rdy;
  logic                       busy;
  logic                       err;

  fullxor_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rnd_vld(rnd_vld), .rnd_data(rnd_data), .rnd_rdy(rnd_rdy),
    .dp_dvld(dp_dvld), .dp_ena(dp_ena), .dp_rnd(dp_rnd), .dp_x(dp_x),
    .dp_z(dp_z), .dp_ovld(dp_ovld),
    .rsp_vld(rsp_vld), .rsp_z(rsp_z), .rsp_id(rsp_id), .rsp_rdy(rsp_rdy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [K_WIDTH-1:0] shareXor(input logic [MASKWIDTH-1:0] x);
    logic [K_WIDTH-1:0] acc = '0;
    for (int i = 0; i < N_SHARES; i++) acc ^= x[i*K_WIDTH +: K_WIDTH];
    return acc;
  endfunction

  // Datapath stub: one-cycle latency, collapses the shares it is handed
  logic               stub_stall = 1'b0;
  logic               stub_ovld  = 1'b0;
  logic [K_WIDTH-1:0] stub_z     = '0;
  always @(posedge clk) begin
    if (dp_ena) begin
      if (dp_dvld) stub_z <= shareXor(dp_x);
      stub_ovld <= dp_dvld;
    end
  end
  assign dp_ovld = stub_ovld & ~stub_stall;
  assign dp_z    = stub_z;

  // Transaction-level model: operation in flight, pending response, clean-up cycles left
  bit                 m_inflight = 0, n_inflight = 0;
  int                 m_age = 0, n_age = 0;
  int                 m_opid = 0, n_opid = 0;
  logic [K_WIDTH-1:0] m_opz = '0, n_opz = '0;
  bit                 m_resp = 0, n_resp = 0;
  logic [K_WIDTH-1:0] m_rz = '0, n_rz = '0;
  int                 m_rid = 0, n_rid = 0;
  int                 m_rr = 0, n_rr = 0;
  bit                 m_err = 0, n_err = 0;
  int                 m_clr = 0, n_clr = 0;

  always @(negedge clk) begin : model_cmp
    logic [N_REQ-1:0]     e_req_rdy;
    logic                 e_rnd_rdy, e_dvld, e_ena, e_rsp_vld, e_busy, e_err;
    logic [MASKWIDTH-1:0] e_x;
    logic [RW-1:0]        e_rnd;
    logic [K_WIDTH-1:0]   e_z;
    logic [ID_W-1:0]      e_id;
    bit                   idle, grant;
    int                   g;
    e_req_rdy = '0; e_rnd_rdy = 0; e_dvld = 0; e_ena = 0; e_rsp_vld = 0;
    e_busy = 0; e_err = 0; e_x = '0; e_rnd = '0; e_z = '0; e_id = '0;
    n_inflight = m_inflight; n_age = m_age; n_opid = m_opid; n_opz = m_opz;
    n_resp = m_resp; n_rz = m_rz; n_rid = m_rid; n_rr = m_rr; n_err = m_err; n_clr = m_clr;
    if (!rst_n) begin
      n_inflight = 0; n_age = 0; n_opid = 0; n_opz = '0; n_resp = 0;
      n_rz = '0; n_rid = 0; n_rr = 0; n_err = 0; n_clr = 0;
    end else begin
      idle = !m_inflight && !m_resp && (m_clr == 0);
      g = -1;
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && req_vld[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
      grant = idle && (g >= 0) && rnd_vld;
      e_busy = !idle; e_rsp_vld = m_resp; e_z = m_rz; e_id = ID_W'(m_rid); e_err = m_err;
      if (grant) begin
        e_req_rdy[g] = 1'b1; e_rnd_rdy = 1; e_dvld = 1; e_ena = 1;
        e_x = req_x[g*MASKWIDTH +: MASKWIDTH]; e_rnd = rnd_data;
        n_inflight = 1; n_age = 1; n_opid = g; n_opz = shareXor(e_x);
      end
      if (m_inflight) begin
        e_ena = 1;
        if (dp_ovld) begin
          n_inflight = 0; n_resp = 1; n_rz = m_opz; n_rid = m_opid;
        end else if (m_age == WAIT_MAX) begin
          n_inflight = 0; n_err = 1; n_rr = (m_opid + 1) % N_REQ;
        end else begin
          n_age = m_age + 1;
        end
      end
      if (m_resp && rsp_rdy) begin
        n_resp = 0; n_rr = (m_rid + 1) % N_REQ;
        if (ZEROIZE) begin n_clr = 2; n_rz = '0; end
      end
      if (m_clr > 0) begin
        e_ena = 1;
        if (m_clr == 2) e_dvld = 1;
        n_clr = m_clr - 1;
      end
    end
    checkOutput("m_req_rdy", req_rdy, e_req_rdy);
    checkOutput("m_rnd_rdy", rnd_rdy, e_rnd_rdy);
    checkOutput("m_dp_dvld", dp_dvld, e_dvld);
    checkOutput("m_dp_ena",  dp_ena,  e_ena);
    checkOutput("m_dp_x",    dp_x,    e_x);
    checkOutput("m_dp_rnd",  dp_rnd,  e_rnd);
    checkOutput("m_rsp_vld", rsp_vld, e_rsp_vld);
    checkOutput("m_rsp_z",   rsp_z,   e_z);
    checkOutput("m_rsp_id",  rsp_id,  e_id);
    checkOutput("m_busy",    busy,    e_busy);
    checkOutput("m_err",     err,     e_err);
  end

  // Commit the model's next values at the clock edge, or clear on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 0; m_age = 0; m_opid = 0; m_opz = '0; m_resp = 0;
      m_rz = '0; m_rid = 0; m_rr = 0; m_err = 0; m_clr = 0;
    end else begin
      m_inflight = n_inflight; m_age = n_age; m_opid = n_opid; m_opz = n_opz;
      m_resp = n_resp; m_rz = n_rz; m_rid = n_rid; m_rr = n_rr; m_err = n_err; m_clr = n_clr;
    end
  end

  // Event log used by the directed scenarios
  int                 cyc = 0;
  int                 gq[$], gcq[$], riq[$], rcq[$];
  logic [K_WIDTH-1:0] rzq[$];
  int                 rnd_cnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_rdy != '0) begin gq.push_back(req_rdy[1] ? 1 : 0); gcq.push_back(cyc); end
      if (rnd_rdy) rnd_cnt++;
      if (rsp_vld && rsp_rdy) begin rzq.push_back(rsp_z); riq.push_back(int'(rsp_id)); rcq.push_back(cyc); end
    end
  end

  function automatic int qAt(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [K_WIDTH-1:0] zAt(input logic [K_WIDTH-1:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0BAD0;
  endfunction

  task automatic clearLog();
    gq.delete(); gcq.delete(); riq.delete(); rcq.delete(); rzq.delete(); rnd_cnt = 0;
  endtask

  // Drive inputs now (caller sits just after a rising edge) and hold them for n cycles
  task automatic applyStimulus(input logic [N_REQ-1:0] vld, input logic rv, input logic rr, input int n);
    req_vld = vld; rnd_vld = rv; rsp_rdy = rr;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [K_WIDTH-1:0] Z0 = 32'h0000_0008;
  localparam logic [K_WIDTH-1:0] Z1 = 32'h1111_1111;

  initial begin
    rst_n = 1'b0; req_vld = '0; rnd_vld = 1'b0; rsp_rdy = 1'b0;
    for (int i = 0; i < N_SHARES; i++) begin
      req_x[i*K_WIDTH +: K_WIDTH]             = K_WIDTH'(i + 1);
      req_x[MASKWIDTH + i*K_WIDTH +: K_WIDTH] = K_WIDTH'(1) << (4 * i);
    end
    for (int i = 0; i < RANDNUM; i++) rnd_data[i*K_WIDTH +: K_WIDTH] = 32'hDEAD_0000 + K_WIDTH'(i);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_rsp_vld", rsp_vld, 0);
    rst_n = 1'b1;

    $display("[TB] single request");
    clearLog();
    applyStimulus(2'b01, 1'b1, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 1'b1, 8);
    checkOutput("single_grants", gq.size(), 1);
    checkOutput("single_grant_id", qAt(gq, 0), 0);
    checkOutput("single_rnd_cnt", rnd_cnt, 1);
    checkOutput("single_rsp_cnt", rzq.size(), 1);
    checkOutput("single_rsp_z", zAt(rzq, 0), Z0);
    checkOutput("single_rsp_id", qAt(riq, 0), 0);
    checkOutput("single_latency", qAt(rcq, 0) - qAt(gcq, 0), 2);

    $display("[TB] contention");
    clearLog();
    applyStimulus(2'b11, 1'b1, 1'b1, 4 * INTERVAL);
    applyStimulus(2'b00, 1'b0, 1'b1, 10);
    checkOutput("cont_grants", gq.size(), 4);
    checkOutput("cont_rnd_cnt", rnd_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("cont_grant_id", qAt(gq, i), (i % 2 == 0) ? 1 : 0);
      checkOutput("cont_rsp_id", qAt(riq, i), (i % 2 == 0) ? 1 : 0);
      checkOutput("cont_rsp_z", zAt(rzq, i), (i % 2 == 0) ? Z1 : Z0);
    end
    for (int i = 0; i < 3; i++) checkOutput("cont_interval", qAt(gcq, i + 1) - qAt(gcq, i), INTERVAL);

    $display("[TB] PRNG starvation");
    clearLog();
    req_vld = 2'b01; rnd_vld = 1'b0; rsp_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("starve_req_rdy", req_rdy, 0);
      checkOutput("starve_busy", busy, 0);
      checkOutput("starve_dp_ena", dp_ena, 0);
      nextCycle();
    end
    rnd_vld = 1'b1;
    @(negedge clk);
    checkOutput("starve_grant", req_rdy, 2'b01);
    checkOutput("starve_rnd_rdy", rnd_rdy, 1);
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1, 8);
    checkOutput("starve_rsp_z", zAt(rzq, 0), Z0);
    checkOutput("starve_rsp_cnt", rzq.size(), 1);

    $display("[TB] backpressure");
    clearLog();
    applyStimulus(2'b11, 1'b1, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_vld", rsp_vld, 1);
      checkOutput("bp_rsp_z", rsp_z, Z1);
      checkOutput("bp_rsp_id", rsp_id, 1);
      checkOutput("bp_no_grant", req_rdy, 0);
      nextCycle();
    end
    req_vld = 2'b00; rnd_vld = 1'b0; rsp_rdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_accept_vld", rsp_vld, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_after_busy", busy, ZEROIZE);
    checkOutput("bp_after_vld", rsp_vld, 0);
`ifdef FULLXOR_SCHED_ZEROIZE_EN
    checkOutput("clr0_dvld", dp_dvld, 1);
    checkOutput("clr0_ena", dp_ena, 1);
    checkOutput("clr0_x", dp_x, 0);
    checkOutput("clr0_rsp_z", rsp_z, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("clr1_dvld", dp_dvld, 0);
    checkOutput("clr1_ena", dp_ena, 1);
`else
    checkOutput("bp_rsp_z_held", rsp_z, Z1);
`endif
    nextCycle();
    applyStimulus(2'b00, 1'b0, 1'b1, 4);
    checkOutput("bp_grants", gq.size(), 1);
    checkOutput("bp_rsp_cnt", rzq.size(), 1);

    $display("[TB] timeout and mid-operation reset");
    clearLog();
    stub_stall = 1'b1;
    applyStimulus(2'b01, 1'b1, 1'b1, 1);
    req_vld = 2'b00; rnd_vld = 1'b0;
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("to_err_before", err, 0);
    checkOutput("to_busy_before", busy, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("to_err", err, 1);
    checkOutput("to_busy", busy, 0);
    checkOutput("to_rsp_vld", rsp_vld, 0);
    nextCycle();
    req_vld = 2'b11; rnd_vld = 1'b1;
    @(negedge clk);
    checkOutput("to_rr_advance", req_rdy, 2'b10);
    nextCycle();
    req_vld = 2'b00; rnd_vld = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_dp_ena", dp_ena, 0);
    checkOutput("rst_dp_dvld", dp_dvld, 0);
    checkOutput("rst_rsp_vld", rsp_vld, 0);
    checkOutput("rst_rsp_z", rsp_z, 0);
    checkOutput("rst_req_rdy", req_rdy, 0);
    checkOutput("to_rsp_cnt", rzq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; stub_stall = 1'b0;

    $display("[TB] request after reset");
    clearLog();
    applyStimulus(2'b10, 1'b1, 1'b1, 1);
    applyStimulus(2'b00, 1'b0, 1'b1, 8);
    checkOutput("post_grant_id", qAt(gq, 0), 1);
    checkOutput("post_rsp_z", zAt(rzq, 0), Z1);
    checkOutput("post_rsp_id", qAt(riq, 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
